// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx_fifo #(
    parameter int F     = 8000000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int DIV = F / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(DEPTH);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t          state, state_n;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      data_q, data_n;
    logic            push, pop, tick, has_data, tx_n;
    assign has_data = level != '0;
    assign tx_ready = level != (AW+1)'(DEPTH);
    assign push     = tx_valid & tx_ready;
    assign tick     = cnt == CW'(DIV - 1);
    assign busy     = state != IDLE;
    // tx is registered, so it is computed from the state being entered
    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = data_q;
        pop     = 1'b0;
        case (state)
            IDLE:   pop = has_data;
            START:  state_n = tick ? DATA : START;
            DATA:   if (tick) begin
                        idx_n   = idx + 3'd1;
                        state_n = idx == 3'd7 ? AFTER_DATA : DATA;
                    end
`ifdef UART_TX_PARITY_EN
            PARITY: state_n = tick ? STOP : PARITY;
`endif
            STOP:   if (tick) begin
                        pop     = has_data;
                        state_n = IDLE;
                    end
            default: state_n = IDLE;
        endcase
        if (pop) begin
            state_n = START;
            idx_n   = '0;
            data_n  = mem[rd_ptr];
        end
        cnt_n = (state == IDLE || tick) ? '0 : cnt + 1'b1;
        tx_n  = state_n == START ? 1'b0 : state_n == DATA ? data_n[idx_n] : 1'b1;
`ifdef UART_TX_PARITY_EN
        if (state_n == PARITY) tx_n = ^data_n;
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            data_q <= '0;
            tx     <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            data_q <= data_n;
            tx     <= tx_n;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= tx_data;
endmodule
